keypad_digit_entry: RTL
=======================

// Module: keypad_digit_entry
// PURPOSE
//  Parametrised successor to the single-digit timer input path. Takes a one-hot decimal keypad,
//  debounces it, and accepts one digit per distinct key press. Accepted digits shift into an
//  NUM_DIGITS-wide BCD entry register. Also emits a one-cycle load strobe per press and a
//  divided 1 Hz tick. Sits between the keypad and the timer counter chain.
// PARAMETERS
//  NUM_DIGITS   4    BCD digits held in the entry register (1..8)
//  DEB_CYCLES   3    consecutive identical samples required to accept a key (>=1)
//  DIV_RATIO    100  CLK_100HZ cycles per CLK_1HZ period (even, >=2)
// PORTS
//  CLK_100HZ  in   1               system clock; all state on rising edge
//  CLR_N      in   1               async active-low reset
//  KPAD       in   10              one-hot key lines, bit k = digit k
//  EN_N       in   1               active-low entry enable
//  D          out  4               BCD code of last accepted digit
//  DIGITS     out  4*NUM_DIGITS    entry register, digit 0 = LSD in [3:0]
//  LOAD_N     out  1               active-low 1-cycle strobe per accepted digit
//  KEY_ERR    out  1               high while >1 key is pressed
//  CLK_1HZ    out  1               divided clock, 50% duty
// BEHAVIOUR
//  - Reset (CLR_N=0, async): D=0, DIGITS=0, LOAD_N=1, KEY_ERR=0, CLK_1HZ=0, FSM=IDLE, div count=0.
//  - Valid sample: exactly one KPAD bit high; code = index of that bit. Zero keys = release.
//    Two or more keys = invalid. KEY_ERR is registered and set 1 cycle after an invalid sample.
//  - FSM (registered, 3 states):
//    IDLE: valid & !EN_N -> DEB; latch code, deb_cnt=1.
//    DEB : same valid code & deb_cnt==DEB_CYCLES-1 -> HELD; accept the digit.
//          same valid code otherwise -> deb_cnt++.
//          different, invalid, released or EN_N=1 -> IDLE.
//    HELD: all keys released -> IDLE. Any other input stays in HELD.
//  - DEB_CYCLES=1: IDLE goes straight to HELD and accepts on the first valid sample.
//  - Accept happens on the clock edge entering HELD.
//    LOAD_N=0 for exactly that next cycle. D<=code.
//    DIGITS<={DIGITS[4*NUM_DIGITS-5:0],code}; the MSD falls off (no wrap, no saturation).
//  - Latency: stable key at cycle 0 -> LOAD_N low in cycle DEB_CYCLES.
//  - Holding a key accepts it once. A second digit needs a release first.
//  - Invalid sample (multi-key) in IDLE/DEB -> IDLE, no accept. In HELD it is ignored until full release.
//  - EN_N=1: FSM forced to IDLE next cycle, LOAD_N=1, D and DIGITS hold.
//    KEY_ERR and the divider keep running.
//  - Divider runs free and ignores EN_N. Count 0..DIV_RATIO-1 then wraps to 0.
//    CLK_1HZ toggles when count==DIV_RATIO/2-1 and when count==DIV_RATIO-1.
//    First rising edge of CLK_1HZ comes DIV_RATIO/2 cycles after reset release.
//  - Reset asserted mid-debounce or mid-strobe aborts immediately. No partial digit is committed.
// CONFIGURATION
//  ENTRY_CLEAR_KEY_EN defined: adds input CLR_KEY (1 bit, active-high, synchronous).
//    CLR_KEY=1 sets DIGITS=0 and D=0 next edge. It overrides a simultaneous accept: no shift,
//    LOAD_N stays 1. The FSM still advances to HELD, so the press is consumed.
//  Macro undefined: no CLR_KEY port. DIGITS clears only via CLR_N.
// STRUCTURE
//  Package keypad_pkg holds:
//    - state encoding localparams ST_IDLE/ST_DEB/ST_HELD
//    - BCD_W=4 and KEY_COUNT=10
//    - a one-hot-to-BCD function returning {valid,code}
//  Sub-module clk_divider (#(DIV_RATIO)) owns the counter and CLK_1HZ.
//  Debounce FSM and shift register stay in the top module.
// TESTING
//  1 Reset: CLR_N=0 for 3 cycles, then release -> all outputs at reset values.
//    CLK_1HZ rises 50 cycles after release, period 100 cycles.
//  2 Single press: EN_N=0, KPAD=10'b0000010000 held 10 cycles (DEB_CYCLES=3).
//    -> one LOAD_N low pulse in cycle 3, D=4, DIGITS=16'h0004.
//  3 Sequence 1,2,3,4,5 with releases between -> DIGITS=16'h2345 (digit 1 shifted out), 5 strobes.
//  4 Bounce: KPAD toggles 0x010/0x000 every cycle for 6 cycles, then holds 0x010
//    -> exactly one strobe, 3 cycles after the stable hold begins.
//  5 Multi-key: KPAD=10'b0100000010 -> KEY_ERR=1 next cycle, no strobe, DIGITS unchanged.
//    After release and KPAD=0x200 -> D=9.
//  6 EN_N=1, KPAD=0x001 for 20 cycles -> no strobe, DIGITS holds.
//    With ENTRY_CLEAR_KEY_EN, CLR_KEY pulse -> DIGITS=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad digit entry path: FSM state encoding,
// BCD/key widths and the one-hot key decoder.
package keypad_pkg;

    localparam int BCD_W     = 4;
    localparam int KEY_COUNT = 10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DEB  = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_DEB  = ST_DEB,
        S_HELD = ST_HELD
    } state_t;

    // Returns {valid, code}. Valid only when exactly one key line is high;
    // code is the index of the highest active line.
    function automatic logic [BCD_W:0] onehot_to_bcd(input logic [KEY_COUNT-1:0] keys);
        logic [BCD_W-1:0] code;
        int unsigned      ones;
        code = '0;
        ones = 0;
        for (int k = 0; k < KEY_COUNT; k++) begin
            if (keys[k]) begin
                ones = ones + 1;
                code = BCD_W'(k);
            end
        end
        return {(ones == 1), code};
    endfunction

endpackage

// File: rtl/keypad_digit_entry_clk_divider.sv
// Free-running divider producing a 50% duty clock of DIV_RATIO input cycles.
module clk_divider #(
    parameter int DIV_RATIO = 100
) (
    input  logic clk,
    input  logic rst_n,
    output logic clk_out
);

    localparam int CNT_W = (DIV_RATIO > 2) ? $clog2(DIV_RATIO) : 1;

    logic [CNT_W-1:0] count;
    logic             wrap;
    logic             toggle;

    assign wrap   = (count == CNT_W'(DIV_RATIO - 1));
    assign toggle = wrap || (count == CNT_W'(DIV_RATIO / 2 - 1));

    // Counter wraps every DIV_RATIO cycles; output flips at half and full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            clk_out <= 1'b0;
        end else begin
            count <= wrap ? '0 : count + CNT_W'(1);
            if (toggle) begin
                clk_out <= ~clk_out;
            end
        end
    end

endmodule

// File: rtl/keypad_digit_entry.sv
// Keypad digit entry: debounces a one-hot decimal keypad, accepts one digit
// per distinct press and shifts it into a BCD entry register.
// Optional feature macro: ENTRY_CLEAR_KEY_EN adds the synchronous CLR_KEY input.
//
// state | meaning
// IDLE  | waiting for a single valid key with entry enabled
// DEB   | same key seen deb_cnt consecutive samples
// HELD  | digit accepted, waiting for full release
module keypad_digit_entry
    import keypad_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DEB_CYCLES = 3,
    parameter int DIV_RATIO  = 100
) (
    input  logic                    CLK_100HZ,
    input  logic                    CLR_N,
    input  logic [KEY_COUNT-1:0]    KPAD,
    input  logic                    EN_N,
`ifdef ENTRY_CLEAR_KEY_EN
    input  logic                    CLR_KEY,
`endif
    output logic [BCD_W-1:0]        D,
    output logic [4*NUM_DIGITS-1:0] DIGITS,
    output logic                    LOAD_N,
    output logic                    KEY_ERR,
    output logic                    CLK_1HZ
);

    localparam int DW  = 4 * NUM_DIGITS;
    localparam int DCW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

    state_t           state, next_state;
    logic [BCD_W-1:0] code_q, next_code;
    logic [DCW-1:0]   deb_cnt, next_cnt;
    logic             accept;
    logic             key_valid;
    logic             key_any;
    logic [BCD_W-1:0] key_code;
    logic             clr_entry;
    logic [DW+3:0]    shift_wide;

    assign {key_valid, key_code} = onehot_to_bcd(KPAD);
    assign key_any    = |KPAD;
    assign shift_wide = {DIGITS, key_code};

`ifdef ENTRY_CLEAR_KEY_EN
    assign clr_entry = CLR_KEY;
`else
    assign clr_entry = 1'b0;
`endif

    // FSM and debounce registers.
    always_ff @(posedge CLK_100HZ or negedge CLR_N) begin
        if (!CLR_N) begin
            state   <= S_IDLE;
            code_q  <= '0;
            deb_cnt <= '0;
        end else begin
            state   <= next_state;
            code_q  <= next_code;
            deb_cnt <= next_cnt;
        end
    end

    // Next-state logic; accept fires on the transition into HELD.
    always_comb begin
        next_state = state;
        next_code  = code_q;
        next_cnt   = deb_cnt;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (key_valid && !EN_N) begin
                    next_code = key_code;
                    if (DEB_CYCLES == 1) begin
                        next_state = S_HELD;
                        accept     = 1'b1;
                    end else begin
                        next_state = S_DEB;
                        next_cnt   = DCW'(1);
                    end
                end
            end
            S_DEB: begin
                if (!EN_N && key_valid && (key_code == code_q)) begin
                    if (deb_cnt == DCW'(DEB_CYCLES - 1)) begin
                        next_state = S_HELD;
                        accept     = 1'b1;
                    end else begin
                        next_cnt = deb_cnt + DCW'(1);
                    end
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_HELD: begin
                if (EN_N || !key_any) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Entry register, last digit and load strobe; a clear beats a same-cycle accept.
    always_ff @(posedge CLK_100HZ or negedge CLR_N) begin
        if (!CLR_N) begin
            D      <= '0;
            DIGITS <= '0;
            LOAD_N <= 1'b1;
        end else if (clr_entry) begin
            D      <= '0;
            DIGITS <= '0;
            LOAD_N <= 1'b1;
        end else if (accept) begin
            D      <= key_code;
            DIGITS <= shift_wide[DW-1:0];
            LOAD_N <= 1'b0;
        end else begin
            LOAD_N <= 1'b1;
        end
    end

    // Multi-key flag, independent of entry enable.
    always_ff @(posedge CLK_100HZ or negedge CLR_N) begin
        if (!CLR_N) begin
            KEY_ERR <= 1'b0;
        end else begin
            KEY_ERR <= key_any && !key_valid;
        end
    end

    clk_divider #(
        .DIV_RATIO(DIV_RATIO)
    ) u_div (
        .clk    (CLK_100HZ),
        .rst_n  (CLR_N),
        .clk_out(CLK_1HZ)
    );

endmodule
